// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: PC handshake, imem request/response
// and the instruction queue head toward decode.
interface instr_fetch_if;
  logic [31:0] pc;
  logic        pc_en;
  logic        redirect;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;
  logic        instr_ready;

  modport master (
    input  pc,
    input  redirect,
    input  imem_rvalid,
    input  imem_rdata,
    input  instr_ready,
    output pc_en,
    output imem_req,
    output imem_addr,
    output instr_valid,
    output instr,
    output instr_pc,
    output instr_fault
  );

  modport slave (
    output pc,
    output redirect,
    output imem_rvalid,
    output imem_rdata,
    output instr_ready,
    input  pc_en,
    input  imem_req,
    input  imem_addr,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    input  instr_fault
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: one-outstanding imem request, tagged
// responses queued in a small FIFO toward decode.
module instr_fetch #(
  parameter int DEPTH = 2
) (
  input logic           clk,
  input logic           reset,
  instr_fetch_if.master bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] LOW  = CW'(DEPTH - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [31:0] pc_q, pc_d;
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;

  logic [31:0] mem_ins [DEPTH];
  logic [31:0] mem_pc  [DEPTH];
  logic [DEPTH-1:0] mem_flt;

  logic        misal;
  logic        rvalid;
  logic        req;
  logic        enq;
  logic        deq;
  logic        flush;
  logic [31:0] enq_pc;
  logic [31:0] enq_ins;
  logic        enq_flt;
  logic        head_vld;

  assign misal    = |bus.pc[1:0];
  assign rvalid   = bus.imem_rvalid;
  assign head_vld = (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req     = 1'b0;
    enq     = 1'b0;
    flush   = 1'b0;
    enq_pc  = pc_q;
    enq_ins = bus.imem_rdata;
    enq_flt = 1'b0;
    if (!reset) begin
      if (bus.redirect) begin
        flush = 1'b1;
        case (state_q)
          S_WAIT:  state_d = rvalid ? S_IDLE : S_DRAIN;
          S_DRAIN: state_d = rvalid ? S_IDLE : S_DRAIN;
          S_HALT:  state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cnt_q < FULL) begin
              if (misal) begin
                enq     = 1'b1;
                enq_pc  = bus.pc;
                enq_ins = 32'h0;
                enq_flt = 1'b1;
                state_d = S_HALT;
              end else begin
                req     = 1'b1;
                pc_d    = bus.pc;
                state_d = S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (rvalid) begin
              enq     = 1'b1;
              state_d = S_IDLE;
              // a misaligned pc here is left for IDLE to fault on
              if (cnt_q <= LOW && !misal) begin
                req     = 1'b1;
                pc_d    = bus.pc;
                state_d = S_WAIT;
              end
            end
          end
          S_DRAIN: begin
            if (rvalid) state_d = S_IDLE;
          end
          default: state_d = S_HALT;
        endcase
      end
    end
  end

  assign deq = head_vld && bus.instr_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      mem_flt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_ins[i] <= '0;
        mem_pc[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (flush) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (enq) begin
          mem_ins[wr_q] <= enq_ins;
          mem_pc[wr_q]  <= enq_pc;
          mem_flt[wr_q] <= enq_flt;
          wr_q          <= wr_q + AW'(1);
        end
        if (deq) rd_q <= rd_q + AW'(1);
        case ({enq, deq})
          2'b10:   cnt_q <= cnt_q + CW'(1);
          2'b01:   cnt_q <= cnt_q - CW'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  assign bus.imem_req    = req;
  assign bus.pc_en       = req;
  assign bus.imem_addr   = bus.pc;
  assign bus.instr_valid = head_vld;
  assign bus.instr       = mem_ins[rd_q];
  assign bus.instr_pc    = mem_pc[rd_q];
  assign bus.instr_fault = mem_flt[rd_q];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: PC register and memory
// modelled here, head entries collected as decode pops them.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  bit auto_mem;
  logic [31:0] tgt;
  logic [31:0] pop_pc [$];
  logic [31:0] pop_ins [$];
  logic pop_flt [$];

  instr_fetch_if bus ();

  instr_fetch #(.DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic rq, en, rd;
    logic [31:0] ad;
    #1;
    rq = bus.imem_req;
    en = bus.pc_en;
    ad = bus.imem_addr;
    rd = bus.redirect;
    if (!reset && !rd && bus.instr_valid && bus.instr_ready) begin
      pop_pc.push_back(bus.instr_pc);
      pop_ins.push_back(bus.instr);
      pop_flt.push_back(bus.instr_fault);
    end
    @(posedge clk);
    #1;
    if (rd) bus.pc = tgt;
    else if (en) bus.pc = bus.pc + 32'd4;
    bus.redirect = 1'b0;
    if (auto_mem) begin
      bus.imem_rvalid = rq;
      bus.imem_rdata  = ad ^ 32'hA5A5_0000;
    end
    #1;
  endtask

  task automatic do_reset(input logic [31:0] pc0);
    reset = 1'b1;
    bus.redirect = 1'b0;
    bus.imem_rvalid = 1'b0;
    auto_mem = 1'b1;
    tick();
    tick();
    bus.pc = pc0;
    bus.imem_rvalid = 1'b0;
    reset = 1'b0;
    pop_pc.delete();
    pop_ins.delete();
    pop_flt.delete();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    auto_mem = 1'b1;
    tgt = '0;
    bus.pc = '0;
    bus.redirect = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    bus.instr_ready = 1'b1;

    // reset state
    tick();
    tick();
    chk("rst_valid", bus.instr_valid, 1'b0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc", bus.instr_pc, 32'h0);
    chk("rst_fault", bus.instr_fault, 1'b0);
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_pc_en", bus.pc_en, 1'b0);

    // streaming, 1-cycle memory
    reset = 1'b0;
    #1;
    chk("s_req0", bus.imem_req, 1'b1);
    chk("s_addr0", bus.imem_addr, 32'h0);
    tick();
    chk("s_pc_en1", bus.pc_en, 1'b1);
    chk("s_addr1", bus.imem_addr, 32'h4);
    tick();
    chk("s_nocredit", bus.pc_en, 1'b0);
    chk("s_hvalid", bus.instr_valid, 1'b1);
    chk("s_hpc", bus.instr_pc, 32'h0);
    chk("s_hins", bus.instr, 32'hA5A5_0000);
    tick();
    tick();
    tick();
    tick();
    chk("s_npop", 32'(pop_pc.size()), 32'd3);
    chk("s_pc0", pop_pc[0], 32'h0);
    chk("s_pc1", pop_pc[1], 32'h4);
    chk("s_pc2", pop_pc[2], 32'h8);
    chk("s_ins0", pop_ins[0], 32'hA5A5_0000);
    chk("s_ins1", pop_ins[1], 32'hA5A5_0004);
    chk("s_ins2", pop_ins[2], 32'hA5A5_0008);
    chk("s_flt", {pop_flt[0], pop_flt[1], pop_flt[2]}, 3'b000);

    // backpressure fills both entries
    do_reset(32'h0);
    bus.instr_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("b_full_req", bus.imem_req, 1'b0);
    chk("b_hvalid", bus.instr_valid, 1'b1);
    chk("b_hpc", bus.instr_pc, 32'h0);
    tick();
    tick();
    chk("b_stall_req", bus.imem_req, 1'b0);
    chk("b_stall_pc", bus.pc, 32'h8);
    bus.instr_ready = 1'b1;
    #1;
    chk("b_deq_nocred", bus.imem_req, 1'b0);
    tick();
    chk("b_resume_req", bus.imem_req, 1'b1);
    chk("b_resume_addr", bus.imem_addr, 32'h8);
    tick();
    tick();
    tick();
    chk("b_npop", 32'(pop_pc.size()), 32'd3);
    chk("b_pc0", pop_pc[0], 32'h0);
    chk("b_pc1", pop_pc[1], 32'h4);
    chk("b_pc2", pop_pc[2], 32'h8);
    chk("b_ins2", pop_ins[2], 32'hA5A5_0008);

    // redirect with the response arriving late
    do_reset(32'h10);
    auto_mem = 1'b0;
    chk("r_addr", bus.imem_addr, 32'h10);
    chk("r_req", bus.imem_req, 1'b1);
    tick();
    bus.redirect = 1'b1;
    tgt = 32'h100;
    #1;
    chk("r_redir_req", bus.imem_req, 1'b0);
    tick();
    chk("r_drain_req", bus.imem_req, 1'b0);
    chk("r_drain_vld", bus.instr_valid, 1'b0);
    tick();
    chk("r_drain_req2", bus.imem_req, 1'b0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("r_disc_req", bus.imem_req, 1'b0);
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    chk("r_disc_vld", bus.instr_valid, 1'b0);
    chk("r_new_req", bus.imem_req, 1'b1);
    chk("r_new_addr", bus.imem_addr, 32'h100);
    auto_mem = 1'b1;
    tick();
    tick();
    chk("r_npop", 32'(pop_pc.size()), 32'd0);
    chk("r_hvalid", bus.instr_valid, 1'b1);
    chk("r_hpc", bus.instr_pc, 32'h100);
    chk("r_hins", bus.instr, 32'hA5A5_0100);

    // redirect on the same edge as the response
    do_reset(32'h20);
    auto_mem = 1'b0;
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'h1111_2222;
    bus.redirect = 1'b1;
    tgt = 32'h80;
    #1;
    chk("c_req", bus.imem_req, 1'b0);
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    chk("c_vld", bus.instr_valid, 1'b0);
    chk("c_req_idle", bus.imem_req, 1'b1);
    chk("c_addr", bus.imem_addr, 32'h80);
    auto_mem = 1'b1;
    tick();
    tick();
    chk("c_npop", 32'(pop_pc.size()), 32'd0);
    chk("c_hpc", bus.instr_pc, 32'h80);
    chk("c_hins", bus.instr, 32'hA5A5_0080);

    // misaligned fetch faults and halts
    do_reset(32'h22);
    bus.instr_ready = 1'b0;
    chk("m_req", bus.imem_req, 1'b0);
    chk("m_pc_en", bus.pc_en, 1'b0);
    tick();
    chk("m_vld", bus.instr_valid, 1'b1);
    chk("m_hpc", bus.instr_pc, 32'h22);
    chk("m_hins", bus.instr, 32'h0);
    chk("m_flt", bus.instr_fault, 1'b1);
    tick();
    tick();
    chk("m_halt_req", bus.imem_req, 1'b0);
    chk("m_halt_pc", bus.pc, 32'h22);
    bus.redirect = 1'b1;
    tgt = 32'h40;
    #1;
    tick();
    chk("m_flush", bus.instr_valid, 1'b0);
    chk("m_res_req", bus.imem_req, 1'b1);
    chk("m_res_addr", bus.imem_addr, 32'h40);
    tick();
    tick();
    chk("m_res_hpc", bus.instr_pc, 32'h40);
    chk("m_res_flt", bus.instr_fault, 1'b0);
    chk("m_res_ins", bus.instr, 32'hA5A5_0040);

    // reset while an entry is queued and a request outstanding
    do_reset(32'h0);
    bus.instr_ready = 1'b0;
    tick();
    auto_mem = 1'b0;
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    chk("x_vld", bus.instr_valid, 1'b1);
    chk("x_wait_req", bus.imem_req, 1'b0);
    reset = 1'b1;
    tick();
    chk("x_rst_vld", bus.instr_valid, 1'b0);
    chk("x_rst_req", bus.imem_req, 1'b0);
    reset = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("x_late_req", bus.imem_req, 1'b1);
    chk("x_late_addr", bus.imem_addr, 32'h8);
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    chk("x_late_vld", bus.instr_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
